// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: WIDTH-bit word in over valid/ready, one bit per clock out on ser_out/ser_valid.
// Latency: a word accepted at edge k drives its first bit after edge k; back-to-back frames have no gap.
// Backpressure: in_ready is high only in IDLE, on the final frame cycle, or in PARITY. Optional parity bit: define PISO_PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_done_q, frame_done_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] shift_val;

    // The shift register holds the bits still to be sent; the bit on ser_out
    // is already removed from it, so the next bit always sits at the exit end.
    assign first_bit = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign load_val  = MSB_FIRST ? (in_data << 1) : (in_data >> 1);
    assign shift_val = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    // Ready only in cycles whose successor can start a new frame without a gap.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:   in_ready = 1'b1;
`ifdef PISO_PARITY_EN
            SHIFT:  in_ready = 1'b0;
            PARITY: in_ready = 1'b1;
`else
            SHIFT:  in_ready = (count_q == LAST);
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Next-state and registered-output logic; an accepted word always reloads,
    // which covers IDLE, the final data bit and the parity cycle alike.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shreg_d      = shreg_q;
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef PISO_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                count_d = '0;
            end
            SHIFT: begin
                if (count_q != LAST) begin
                    count_d      = count_q + CW'(1);
                    shreg_d      = shift_val;
                    ser_out_d    = next_bit;
                    ser_valid_d  = 1'b1;
`ifndef PISO_PARITY_EN
                    frame_done_d = ((count_q + CW'(1)) == LAST);
`endif
                end else begin
`ifdef PISO_PARITY_EN
                    state_d      = PARITY;
                    ser_out_d    = par_q;
                    ser_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
`else
                    state_d      = IDLE;
                    count_d      = '0;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                count_d = '0;
            end
`endif
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        if (accept) begin
            state_d      = SHIFT;
            count_d      = '0;
            shreg_d      = load_val;
            ser_out_d    = first_bit;
            ser_valid_d  = 1'b1;
            frame_done_d = 1'b0;
`ifdef PISO_PARITY_EN
            par_d        = ^in_data;
`endif
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shreg_q      <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shreg_q      <= shreg_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
`ifdef PISO_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first and LSB-first), WIDTH=4.
// Expected frame bits are queued at each accept edge and compared on every falling edge.
// Honours PISO_PARITY_EN for the extra parity bit and the shifted ready window.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] in_data;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] ser_out;
    logic [1:0] ser_valid;
    logic [1:0] busy;
    logic [1:0] frame_done;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit last;
    } item_t;

    typedef struct {
        int         inst;
        logic [3:0] data;
        logic [3:0] exp;   // transmit order, leftmost bit first
        logic       par;
    } vec_t;

    item_t sbq[2][$];
    vec_t  vecs[6];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: a non-empty queue means a frame bit must be on the wire now.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                item_t it;
                bit    exp_v;
                exp_v = (sbq[i].size() != 0);
                chk(ser_valid[i] === exp_v, $sformatf("ser_valid[%0d]", i), int'(ser_valid[i]), int'(exp_v));
                if (exp_v) begin
                    it = sbq[i].pop_front();
                    chk(ser_out[i] === it.b, $sformatf("ser_out[%0d]", i), int'(ser_out[i]), int'(it.b));
                    chk(frame_done[i] === it.last, $sformatf("frame_done[%0d]", i), int'(frame_done[i]), int'(it.last));
                end else begin
                    chk(ser_out[i] === 1'b0, $sformatf("idle_ser_out[%0d]", i), int'(ser_out[i]), 0);
                    chk(frame_done[i] === 1'b0, $sformatf("idle_frame_done[%0d]", i), int'(frame_done[i]), 0);
                end
            end
        end
    end

    // Offer a word until accepted; queue its expected bits at the accept edge.
    task automatic send(input int inst, input logic [3:0] d, input logic [3:0] exp,
                        input logic par, output int waits);
        bit got;
        in_data        = d;
        in_valid[inst] = 1'b1;
        waits          = 0;
        got            = 1'b0;
        while (!got) begin
            @(negedge clk);
            if (in_ready[inst] === 1'b1) begin
                got = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    chk(1'b0, "accept_timeout", waits, 0);
                    in_valid[inst] = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            item_t it;
            it.b    = exp[3-j];
            it.last = (j == 3) && !PAR_EN;
            sbq[inst].push_back(it);
        end
        if (PAR_EN) begin
            item_t pt;
            pt.b    = par;
            pt.last = 1'b1;
            sbq[inst].push_back(pt);
        end
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int exp_wait_b2b;
        int exp_wait_mid;
        exp_wait_b2b = PAR_EN ? 4 : 3;
        exp_wait_mid = PAR_EN ? 3 : 2;

        vecs[0] = '{0, 4'b1011, 4'b1011, 1'b1};
        vecs[1] = '{0, 4'b1001, 4'b1001, 1'b0};
        vecs[2] = '{1, 4'b1011, 4'b1101, 1'b1};
        vecs[3] = '{0, 4'b0000, 4'b0000, 1'b0};
        vecs[4] = '{1, 4'b1000, 4'b0001, 1'b1};
        vecs[5] = '{0, 4'b0110, 4'b0110, 1'b0};

        rst      = 1'b0;
        in_data  = 4'h0;
        in_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(ser_out[i] === 1'b0, "rst_ser_out", int'(ser_out[i]), 0);
            chk(ser_valid[i] === 1'b0, "rst_ser_valid", int'(ser_valid[i]), 0);
            chk(busy[i] === 1'b0, "rst_busy", int'(busy[i]), 0);
            chk(frame_done[i] === 1'b0, "rst_frame_done", int'(frame_done[i]), 0);
            chk(in_ready[i] === 1'b1, "rst_in_ready", int'(in_ready[i]), 1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single frames from the table, each drained back to IDLE.
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].inst, vecs[v].data, vecs[v].exp, vecs[v].par, w);
            chk(w == 0, "idle_accept_wait", w, 0);
            chk(busy[vecs[v].inst] === 1'b1, "busy_in_frame", int'(busy[vecs[v].inst]), 1);
            idle(7);
            chk(busy[vecs[v].inst] === 1'b0, "busy_after_frame", int'(busy[vecs[v].inst]), 0);
        end

        // Back-to-back words with in_valid held high.
        send(0, 4'hA, 4'b1010, 1'b0, w);
        chk(w == 0, "b2b_first_wait", w, 0);
        send(0, 4'h5, 4'b0101, 1'b0, w);
        chk(w == exp_wait_b2b, "b2b_second_wait", w, exp_wait_b2b);
        idle(8);

        // Word offered mid-frame is held off until the frame's last cycle.
        send(0, 4'hA, 4'b1010, 1'b0, w);
        idle(1);
        chk(in_ready[0] === 1'b0, "midframe_in_ready", int'(in_ready[0]), 0);
        send(0, 4'h3, 4'b0011, 1'b0, w);
        chk(w == exp_wait_mid, "midframe_wait", w, exp_wait_mid);
        idle(8);

        // Asynchronous reset after the second bit of 4'hF.
        send(0, 4'hF, 4'b1111, 1'b0, w);
        in_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        #1;
        chk(ser_out[0] === 1'b0, "arst_ser_out", int'(ser_out[0]), 0);
        chk(ser_valid[0] === 1'b0, "arst_ser_valid", int'(ser_valid[0]), 0);
        chk(busy[0] === 1'b0, "arst_busy", int'(busy[0]), 0);
        chk(frame_done[0] === 1'b0, "arst_frame_done", int'(frame_done[0]), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk(in_ready[0] === 1'b1, "post_rst_in_ready", int'(in_ready[0]), 1);
        idle(6);

        chk(sbq[0].size() == 0, "sb0_drained", sbq[0].size(), 0);
        chk(sbq[1].size() == 0, "sb1_drained", sbq[1].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
